// File: rtl/core_pkg.sv
// Shared constants, state encoding and pipeline-register payload for the core.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fills the IF/ID register, parks after EBREAK.
module fetch_stage
    import core_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  id_ready_i,
    output logic                  id_valid_o,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [DATA_WIDTH-1:0] id_pc_o,
    output logic                  halted_o
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    if_id_t                if_id_q, if_id_d;
    fetch_state_e          state_q, state_d;
    logic                  halted_q, halted_d;
    logic                  advance;

    // Next-state: redirect beats everything, then advance, then halt drain.
    always_comb begin
        pc_d     = pc_q;
        if_id_d  = if_id_q;
        state_d  = state_q;
        halted_d = halted_q;
        advance  = (state_q == FETCH_RUN) && (!if_id_q.valid || id_ready_i);

        if (redirect_i) begin
            pc_d          = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            if_id_d.valid = 1'b0;
            state_d       = FETCH_RUN;
            halted_d      = 1'b0;
        end else if (advance) begin
            if_id_d.valid = 1'b1;
            if_id_d.instr = XLEN'(imem_instr_i);
            if_id_d.pc    = XLEN'(pc_q);
            pc_d          = pc_q + DATA_WIDTH'(4);
            if (XLEN'(imem_instr_i) == EBREAK_INSTR) begin
                state_d  = FETCH_HALT;
                halted_d = 1'b1;
            end
        end else if (state_q == FETCH_HALT && if_id_q.valid && id_ready_i) begin
            if_id_d.valid = 1'b0;
        end
    end

    // PC, IF/ID register and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_q.valid <= 1'b0;
            if_id_q.instr <= NOP_INSTR;
            if_id_q.pc    <= '0;
            state_q       <= FETCH_RUN;
            halted_q      <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign id_valid_o  = if_id_q.valid;
    assign id_instr_o  = DATA_WIDTH'(if_id_q.instr);
    assign id_pc_o     = DATA_WIDTH'(if_id_q.pc);
    assign halted_o    = halted_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the scalar RISC-V pipeline. Owns the program counter and drives the byte address into the combinational instruction memory. Captures the returned word together with its PC into the IF/ID register and hands it to decode over a valid/ready handshake. Accepts redirects from execute and parks itself after fetching EBREAK.

## Interface
- `DATA_WIDTH`, 32: width of PC, address and instruction.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr_o` out DATA_WIDTH: byte address to instruction memory; equals current PC.
- `imem_instr_i` in DATA_WIDTH: instruction word returned combinationally for `imem_addr_o` in the same cycle.
- `redirect_i` in 1: execute requests a PC change (taken branch, jump, trap).
- `redirect_pc_i` in DATA_WIDTH: redirect target byte address.
- `id_ready_i` in 1: decode accepts the IF/ID contents this cycle.
- `id_valid_o` out 1: IF/ID holds a valid instruction.
- `id_instr_o` out DATA_WIDTH: fetched instruction.
- `id_pc_o` out DATA_WIDTH: byte address the instruction was fetched from.
- `halted_o` out 1: EBREAK has been fetched; sequential fetch stopped.

## Operation
- FSM with two states: `FETCH_RUN` and `FETCH_HALT`. Reset state is `FETCH_RUN`.
- `imem_addr_o` = `pc_q`, combinationally, in both states.
- An advance occurs when the state is `FETCH_RUN` and (`!id_valid_o || id_ready_i`). On an advance, in one edge:
  - `id_instr_o` <= `imem_instr_i`;
  - `id_pc_o` <= `pc_q`;
  - `id_valid_o` <= 1;
  - `pc_q` <= `pc_q + 4`.
- EBREAK (32'h0010_0073) captured on an advance: it is still delivered to decode. The FSM moves to `FETCH_HALT` and `halted_o` <= 1. `pc_q` still advances by 4.
- Stall (`id_valid_o && !id_ready_i`, no redirect): IF/ID registers, `pc_q` and the FSM hold unchanged.
- In `FETCH_HALT`: no new capture. When `id_ready_i` is 1 while `id_valid_o` is 1, `id_valid_o` <= 0. All other state holds.
- Redirect has highest priority, beating advance, stall, halt and EBREAK capture in the same cycle. On a redirect:
  - `pc_q` <= `{redirect_pc_i[DATA_WIDTH-1:2], 2'b00}`; the low two bits are discarded;
  - `id_valid_o` <= 0, so any held or incoming instruction is dropped;
  - the FSM goes to `FETCH_RUN` and `halted_o` <= 0.
- PC arithmetic is modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- No bounds check on the PC; the address range is the memory's concern.

## Timing
- Reset values (asserted immediately on `rst_n` falling, independent of `clk`):
  - `pc_q` = `RESET_PC`, so `imem_addr_o` = `RESET_PC`;
  - `id_valid_o` = 0;
  - `id_instr_o` = 32'h0000_0013 (NOP);
  - `id_pc_o` = 0;
  - `halted_o` = 0.
- First rising edge after `rst_n` deasserts captures the word at `RESET_PC`; `id_valid_o` = 1 in the following cycle.
- Fetch latency is one cycle: the PC presented in cycle N appears on `id_*` in cycle N+1.
- Throughput is one instruction per cycle while `id_ready_i` stays high.
- Redirect penalty: the redirect edge clears `id_valid_o` and loads the target. The next edge captures the target instruction. This gives exactly one bubble cycle.
- `id_*` outputs are stable during a stall. Decode may sample them in any stalled cycle.
- Reset mid-stream: all in-flight state is lost; fetch restarts at `RESET_PC`.

## Structure
- `core_pkg` holds the shared items:
  - `NOP_INSTR` = 32'h0000_0013;
  - `EBREAK_INSTR` = 32'h0010_0073;
  - `fetch_state_e` = {`FETCH_RUN`, `FETCH_HALT`};
  - an `if_id_t` struct {valid, instr, pc} for the pipeline register.
- No sub-module. PC register, IF/ID register and FSM sit in one `always_ff` plus one `always_comb` for next-state.

## Test plan
- Reset, then `id_ready_i`=1, memory holding 0x00100093, 0x00200113: `id_pc_o`=0x0 then 0x4 on consecutive cycles with matching instructions. `imem_addr_o` steps 0x0, 0x4, 0x8.
- Hold `id_ready_i`=0 for 3 cycles with `id_valid_o`=1 at PC 0x8: `id_instr_o`, `id_pc_o` and `imem_addr_o`=0xC stay frozen. Release, and PC 0xC appears next cycle.
- `redirect_i`=1, `redirect_pc_i`=0x22 during a stall: next cycle `id_valid_o`=0 and `imem_addr_o`=0x20. The following cycle delivers `id_pc_o`=0x20.
- EBREAK at 0x34: it is delivered with `id_pc_o`=0x34 and `halted_o`=1. After it is consumed, `id_valid_o`=0 permanently. A later redirect to 0x0 clears `halted_o` and fetching resumes.
- Redirect to 0xFFFF_FFFC: next fetch shows `id_pc_o`=0xFFFF_FFFC, then `imem_addr_o` wraps to 0x0.
- Assert `rst_n`=0 asynchronously mid-stream at PC 0x18: all outputs take reset values before the next clock edge.
